// File: rtl/huffman_pkg.sv
// Shared defaults, config-select encodings and width helper for the canonical Huffman decoder.
package huffman_pkg;
  localparam int BW_DEF        = 4;
  localparam int NUM_WORDS_DEF = 8;
  localparam int MAX_LEN_DEF   = 10;

  typedef enum logic {CFG_CNT = 1'b0, CFG_SYM = 1'b1} cfg_sel_e;

  // One spare bit so (first+cnt)<<1 at the deepest level cannot overflow.
  function automatic int code_w(input int max_len);
    return max_len + 1;
  endfunction
endpackage

// File: rtl/huffman_pack_buf.sv
// Symbol packer: assembly buffer filled top slot first, output register with valid/ready,
// and stall generation while a finished word (or a pending flush) waits for the output.
module huffman_pack_buf
  import huffman_pkg::*;
#(
  parameter int BW        = BW_DEF,
  parameter int NUM_WORDS = NUM_WORDS_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sym_we_i,
  input  logic [BW-1:0]           sym_i,
  input  logic                    flush_i,
  input  logic                    ready_i,
  output logic [BW*NUM_WORDS-1:0] out_o,
  output logic                    valid_o,
  output logic                    stall_o
);
  localparam int PW = $clog2(NUM_WORDS);
  localparam logic [PW-1:0] TOP = PW'(NUM_WORDS - 1);

  logic [NUM_WORDS-1:0][BW-1:0] buf_q, buf_d, word;
  logic [BW*NUM_WORDS-1:0]      out_q, out_d;
  logic [PW-1:0]                ptr_q, ptr_d;
  logic                         valid_q, valid_d, full_q, full_d, pend_q, pend_d;
  logic                         out_free, nonempty, last_slot, want;

  always_comb begin
    buf_d     = buf_q;
    out_d     = out_q;
    ptr_d     = ptr_q;
    valid_d   = valid_q;
    full_d    = full_q;
    pend_d    = pend_q;
    out_free  = !valid_q || ready_i;
    nonempty  = full_q || (ptr_q != TOP);
    last_slot = sym_we_i && (ptr_q == '0);
    word      = buf_q;
    if (sym_we_i) word[ptr_q] = sym_i;
    if (valid_q && ready_i) valid_d = 1'b0;
    want = last_slot || full_q || ((flush_i || pend_q) && nonempty);
    if (want) begin
      if (out_free) begin
        // Slots never written are still zero, so a flushed word is zero-filled.
        out_d   = word;
        valid_d = 1'b1;
        buf_d   = '0;
        ptr_d   = TOP;
        full_d  = 1'b0;
        pend_d  = 1'b0;
      end else begin
        buf_d  = word;
        full_d = full_q || last_slot;
        pend_d = pend_q || flush_i;
      end
    end else begin
      buf_d  = word;
      pend_d = 1'b0;
      if (sym_we_i) ptr_d = ptr_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_q   <= '0;
      out_q   <= '0;
      ptr_q   <= TOP;
      valid_q <= 1'b0;
      full_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      buf_q   <= buf_d;
      out_q   <= out_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      full_q  <= full_d;
      pend_q  <= pend_d;
    end
  end

  assign out_o   = out_q;
  assign valid_o = valid_q;
  assign stall_o = full_q || pend_q;
endmodule

// File: rtl/huffman_canon_dec.sv
// Programmable canonical-Huffman bit-serial decoder with runtime-loaded cnt/sym tables.
// Optional HUFF_FLUSH_EN: flush pulse emits the partial word and aborts any code in flight.
module huffman_canon_dec
  import huffman_pkg::*;
#(
  parameter  int BW        = BW_DEF,
  parameter  int NUM_WORDS = NUM_WORDS_DEF,
  parameter  int MAX_LEN   = MAX_LEN_DEF,
  localparam int LW        = $clog2(MAX_LEN + 1),
  localparam int AW        = (BW > LW) ? BW : LW
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in,
  input  logic                    valid_in,
  output logic                    ready_in,
  input  logic                    cfg_we,
  input  logic                    cfg_sel,
  input  logic [AW-1:0]           cfg_addr,
  input  logic [BW:0]             cfg_wdata,
  input  logic                    flush,
  output logic [BW*NUM_WORDS-1:0] out,
  output logic                    valid,
  input  logic                    ready,
  output logic                    err
);
  localparam int CW = code_w(MAX_LEN);

  logic [BW:0]    cnt_q [MAX_LEN+1];
  logic [BW-1:0]  sym_q [2**BW];
  logic [LW-1:0]  len_q, len_d, lp1;
  logic [CW-1:0]  code_q, code_d, first_q, first_d, c, off;
  logic [BW:0]    index_q, index_d, n;
  logic [BW-1:0]  sym_addr;
  logic           err_q, err_d, acc, hit, last, sym_we, stall, flush_en;

`ifdef HUFF_FLUSH_EN
  assign flush_en = flush;
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign flush_en     = 1'b0;
`endif

  assign ready_in = !cfg_we && !stall && !flush_en;
  assign acc      = valid_in && ready_in;

  always_comb begin
    lp1      = len_q + 1'b1;
    n        = cnt_q[lp1];
    c        = code_q | CW'(in);
    off      = c - first_q;
    hit      = off < CW'(n);
    last     = lp1 == LW'(MAX_LEN);
    sym_addr = index_q[BW-1:0] + off[BW-1:0];
    sym_we   = acc && hit;
    len_d    = len_q;
    code_d   = code_q;
    first_d  = first_q;
    index_d  = index_q;
    err_d    = err_q;
    if (flush_en || (acc && (hit || last))) begin
      len_d   = '0;
      code_d  = '0;
      first_d = '0;
      index_d = '0;
      if (acc && !hit) err_d = 1'b1;
    end else if (acc) begin
      index_d = index_q + n;
      first_d = (first_q + CW'(n)) << 1;
      code_d  = c << 1;
      len_d   = lp1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q   <= '0;
      code_q  <= '0;
      first_q <= '0;
      index_q <= '0;
      err_q   <= 1'b0;
    end else begin
      len_q   <= len_d;
      code_q  <= code_d;
      first_q <= first_d;
      index_q <= index_d;
      err_q   <= err_d;
    end
  end

  // Table writes; cnt address 0 and anything past MAX_LEN are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i <= MAX_LEN; i++) cnt_q[i] <= '0;
      for (int i = 0; i < 2**BW; i++) sym_q[i] <= '0;
    end else if (cfg_we) begin
      if (cfg_sel_e'(cfg_sel) == CFG_CNT) begin
        if (cfg_addr != '0 && cfg_addr <= AW'(MAX_LEN)) cnt_q[cfg_addr] <= cfg_wdata;
      end else if ((cfg_addr >> BW) == '0) begin
        sym_q[cfg_addr[BW-1:0]] <= cfg_wdata[BW-1:0];
      end
    end
  end

  huffman_pack_buf #(.BW(BW), .NUM_WORDS(NUM_WORDS)) u_pack (
    .clk      (clk),
    .reset    (reset),
    .sym_we_i (sym_we),
    .sym_i    (sym_q[sym_addr]),
    .flush_i  (flush_en),
    .ready_i  (ready),
    .out_o    (out),
    .valid_o  (valid),
    .stall_o  (stall)
  );

  assign err = err_q;
endmodule
